pix_clk_en_gen: RTL and testbench
=================================

# pix_clk_en_gen

Parametrised pixel-rate clock-enable generator for the video path. It runs entirely on the 100 MHz system clock and uses a fractional phase accumulator (increment/modulus pair per video mode) to emit a one-cycle pixel strobe at the exact average pixel rate, e.g. 25.175 MHz. It supports runtime mode switching through a request/acknowledge handshake, and asserts `locked` only after the new rate has produced a stable run of strobes. The timing generator and pixel pipeline consume `pix_ce` as a clock enable rather than a derived clock.

## Interface
- `ACC_W`, 16: phase accumulator width; must satisfy 2^ACC_W > max(MOD + INC) of the mode table.
- `NUM_MODES`, 4: number of entries in the mode table (1..16).
- `DEFAULT_MODE`, 0: mode loaded at reset.
- `LOCK_CYCLES`, 16: `pix_ce` pulses that must occur after a (re)load before `locked` asserts.
- `clk_in`  in  1  system clock, 100 MHz.
- `resetn`  in  1  asynchronous, active-low reset.
- `mode_sel`  in  4  requested mode index; sampled only with `mode_req`.
- `mode_req`  in  1  single-cycle request to switch mode.
- `mode_ack`  out  1  single-cycle pulse when the requested mode is loaded.
- `mode_err`  out  1  single-cycle pulse when a request is rejected.
- `busy`  out  1  high in DRAIN and LOCKING; requests are ignored while high.
- `cur_mode`  out  4  index of the active mode.
- `pix_ce`  out  1  registered pixel strobe, high for one `clk_in` cycle.
- `locked`  out  1  rate stable; high only in RUN.

## Operation
- Mode table entries are {INC, MOD} with 0 < INC <= MOD:
  - mode 0: 1/4 (25.000 MHz)
  - mode 1: 1007/4000 (25.175 MHz)
  - mode 2: 2/5 (40 MHz)
  - mode 3: 13/20 (65 MHz)
- Accumulator step, every cycle in every state: `nxt = acc + INC`.
  - If `nxt >= MOD`: `acc <= nxt - MOD`, `pix_ce <= 1`.
  - Otherwise: `acc <= nxt`, `pix_ce <= 0`.
- Arithmetic is unsigned at ACC_W bits with no overflow by construction. `acc` never reaches MOD.
- FSM states: LOCKING, RUN, DRAIN.
  - LOCKING: a lock counter (clog2(LOCK_CYCLES+1) bits) increments on each `pix_ce`. On reaching LOCK_CYCLES, the FSM goes to RUN, `locked <= 1`, and the counter clears.
  - RUN: on `mode_req` with `mode_sel < NUM_MODES`, latch the pending mode and go to DRAIN. On `mode_req` with `mode_sel >= NUM_MODES`, pulse `mode_err` next cycle and stay in RUN.
  - DRAIN: `locked <= 0`. Wait for the next cycle in which `pix_ce` is registered high. On the following edge, load the pending INC/MOD, set `acc <= 0`, update `cur_mode`, pulse `mode_ack`, and go to LOCKING.
- `mode_req` arriving in DRAIN or LOCKING is ignored: no ack, no err.
- If `mode_req` coincides with a `pix_ce` pulse in RUN, the DRAIN state still waits for the subsequent strobe. The strobe is never cut short.
- A request for the already-active mode performs the full DRAIN/reload/LOCKING sequence. This is how software re-phases the strobe.
- Reset at any time, including mid-DRAIN or mid-LOCKING, discards the pending mode and returns to the DEFAULT_MODE reset state.

## Timing
- Reset values:
  - `acc` = 0, state = LOCKING, `cur_mode` = DEFAULT_MODE
  - `pix_ce`, `locked`, `mode_ack`, `mode_err` = 0
  - `busy` = 1
- Mode 0 after reset release: `pix_ce` is high after the 4th rising edge, then every 4 cycles.
- `locked` rises on the edge after the LOCK_CYCLES-th strobe. For mode 0 with LOCK_CYCLES=16, that is edge 65.
- `mode_ack` and the new INC/MOD take effect on the edge after the draining strobe. The first new-rate strobe follows ceil(MOD/INC) cycles later.
- `busy` is combinational from state. All other outputs are registered.

## Configuration
- `PIX_CLK_OUT_EN`: defined adds output port `clk_pix` (1 bit), a register toggled on every `pix_ce` and reset to 0.
  - This gives a 50 %-ish square wave at half the strobe rate, intended for a scope or debug pin only, never as a clock.
  - Undefined: the port and register are absent. All other behaviour is identical.

## Structure
- Shared package `pix_clk_pkg` holds:
  - the mode-table constants (INC/MOD arrays, indexed by mode)
  - the FSM state enum {LOCKING, RUN, DRAIN}
  - the MODE_W = 4 constant
- One sub-module, `pix_phase_acc`:
  - accumulator plus strobe compare
  - inputs: load, inc, mod
  - output: ce
- The FSM, lock counter and handshake stay in the top module.

## Test plan
- Reset release in mode 0: `pix_ce` first at edge 4, period exactly 4; `locked` = 1 at edge 65; `cur_mode` = 0.
- Mode 1 long run: over 4000 cycles, exactly 1007 strobes; strobe spacing is always 3 or 4 cycles.
- Switch 0→3 while locked: `locked` drops next cycle; `mode_ack` comes the edge after the next strobe; then 13 strobes per 20 cycles; `locked` returns after 16 strobes.
- `mode_sel` = 7 with NUM_MODES = 4: `mode_err` pulses once; `locked`, `cur_mode` and `pix_ce` cadence are unchanged.
- `mode_req` during LOCKING, and `mode_req` coinciding with `pix_ce`: the first is ignored (no ack, no err); the second waits for the following strobe before acking.
- `resetn` asserted mid-DRAIN toward mode 2: on release, mode 0 with a period-4 strobe, and no `mode_ack` ever issued.

Source files
------------

// File: rtl/pix_clk_en_gen_pkg.sv
// -----------------------------------------------------------------------------
// pix_clk_pkg
// Shared definitions for the pixel clock-enable generator:
//   MODE_W            width of a mode index
//   MODE_INC/MODE_MOD the {INC, MOD} phase-step table, indexed by mode
//   pix_state_e       control FSM states {LOCKING, RUN, DRAIN}
//   mode_inc/mode_mod table lookups that fall back to mode 0 for indices
//                     beyond the table
// -----------------------------------------------------------------------------
package pix_clk_pkg;

    localparam int MODE_W     = 4;
    localparam int TABLE_SIZE = 4;

    // Average strobe rate = 100 MHz * INC / MOD
    //   0: 1/4        -> 25.000 MHz
    //   1: 1007/4000  -> 25.175 MHz
    //   2: 2/5        -> 40 MHz
    //   3: 13/20      -> 65 MHz
    localparam int unsigned MODE_INC [TABLE_SIZE] = '{1, 1007, 2, 13};
    localparam int unsigned MODE_MOD [TABLE_SIZE] = '{4, 4000, 5, 20};

    typedef enum logic [1:0] {
        LOCKING = 2'd0,
        RUN     = 2'd1,
        DRAIN   = 2'd2
    } pix_state_e;

    // The table has four entries, so the low two index bits select the entry
    // once the range check has passed.
    function automatic int unsigned mode_inc(input logic [MODE_W-1:0] idx);
        if (int'(idx) < TABLE_SIZE) begin
            return MODE_INC[idx[1:0]];
        end
        return MODE_INC[0];
    endfunction

    function automatic int unsigned mode_mod(input logic [MODE_W-1:0] idx);
        if (int'(idx) < TABLE_SIZE) begin
            return MODE_MOD[idx[1:0]];
        end
        return MODE_MOD[0];
    endfunction

endpackage

// File: rtl/pix_clk_en_gen_if.sv
// -----------------------------------------------------------------------------
// pix_clk_en_gen_if
// Mode-control handshake and strobe outputs of pix_clk_en_gen.
//   mode_sel  [MODE_W] requested mode index (master -> slave)
//   mode_req           single-cycle switch request (master -> slave)
//   mode_ack           pulse: requested mode loaded (slave -> master)
//   mode_err           pulse: request rejected (slave -> master)
//   busy               switching in progress, requests ignored
//   cur_mode  [MODE_W] active mode index
//   pix_ce             one-cycle pixel strobe
//   locked             rate stable
//   clk_pix            debug square wave, present only with PIX_CLK_OUT_EN
// -----------------------------------------------------------------------------
interface pix_clk_en_gen_if;
    import pix_clk_pkg::*;

    logic [MODE_W-1:0] mode_sel;
    logic              mode_req;
    logic              mode_ack;
    logic              mode_err;
    logic              busy;
    logic [MODE_W-1:0] cur_mode;
    logic              pix_ce;
    logic              locked;
`ifdef PIX_CLK_OUT_EN
    logic              clk_pix;
`endif

    modport master (
        output mode_sel,
        output mode_req,
        input  mode_ack,
        input  mode_err,
        input  busy,
        input  cur_mode,
        input  pix_ce,
        input  locked
`ifdef PIX_CLK_OUT_EN
        ,
        input  clk_pix
`endif
    );

    modport slave (
        input  mode_sel,
        input  mode_req,
        output mode_ack,
        output mode_err,
        output busy,
        output cur_mode,
        output pix_ce,
        output locked
`ifdef PIX_CLK_OUT_EN
        ,
        output clk_pix
`endif
    );

endinterface

// File: rtl/pix_clk_en_gen_phase_acc.sv
// -----------------------------------------------------------------------------
// pix_phase_acc
// Fractional phase accumulator. Every cycle acc advances by inc; when it
// reaches mod it wraps by mod and a one-cycle strobe is registered.
//   clk_in   system clock
//   resetn   asynchronous active-low reset
//   load     restart phase: acc cleared, no strobe this edge
//   inc      phase increment (0 < inc <= mod)
//   mod      phase modulus
//   ce       registered strobe
// -----------------------------------------------------------------------------
module pix_phase_acc #(
    parameter int ACC_W = 16
) (
    input  logic             clk_in,
    input  logic             resetn,
    input  logic             load,
    input  logic [ACC_W-1:0] inc,
    input  logic [ACC_W-1:0] mod,
    output logic             ce
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] nxt;
    logic             ce_q, ce_d;

    // acc < mod and inc <= mod, and ACC_W leaves headroom above mod + inc,
    // so the sum cannot wrap.
    always_comb begin
        nxt  = acc_q + inc;
        acc_d = nxt;
        ce_d  = 1'b0;
        if (load) begin
            acc_d = '0;
        end else if (nxt >= mod) begin
            acc_d = nxt - mod;
            ce_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            acc_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ce_q  <= ce_d;
        end
    end

    assign ce = ce_q;

endmodule

// File: rtl/pix_clk_en_gen.sv
// -----------------------------------------------------------------------------
// pix_clk_en_gen
// Pixel-rate clock-enable generator on the system clock. A fractional phase
// accumulator emits pix_ce at INC/MOD of the clock rate; modes are switched
// through a request/acknowledge handshake and locked reports a stable rate.
//   clk_in   system clock (100 MHz)
//   resetn   asynchronous active-low reset
//   bus      pix_clk_en_gen_if.slave: mode_sel, mode_req, mode_ack, mode_err,
//            busy, cur_mode, pix_ce, locked (+ clk_pix)
// Optional feature macro: PIX_CLK_OUT_EN adds clk_pix, a register toggled on
// every pix_ce (debug pin only, never a clock).
// -----------------------------------------------------------------------------
module pix_clk_en_gen
    import pix_clk_pkg::*;
#(
    parameter int ACC_W        = 16,
    parameter int NUM_MODES    = 4,
    parameter int DEFAULT_MODE = 0,
    parameter int LOCK_CYCLES  = 16
) (
    input  logic             clk_in,
    input  logic             resetn,
    pix_clk_en_gen_if.slave  bus
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [MODE_W-1:0] RST_MODE = MODE_W'(DEFAULT_MODE);
    localparam logic [ACC_W-1:0]  RST_INC  = ACC_W'(mode_inc(RST_MODE));
    localparam logic [ACC_W-1:0]  RST_MOD  = ACC_W'(mode_mod(RST_MODE));

    pix_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [MODE_W-1:0] pend_q, pend_d;
    logic [MODE_W-1:0] cur_q, cur_d;
    logic [ACC_W-1:0]  inc_q, inc_d;
    logic [ACC_W-1:0]  mod_q, mod_d;
    logic              locked_q, locked_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              acc_load;
    logic              mode_ok;
    logic              pix_ce;

    pix_phase_acc #(
        .ACC_W (ACC_W)
    ) u_phase_acc (
        .clk_in (clk_in),
        .resetn (resetn),
        .load   (acc_load),
        .inc    (inc_q),
        .mod    (mod_q),
        .ce     (pix_ce)
    );

    // One extra bit so NUM_MODES = 16 compares correctly.
    assign mode_ok = ({1'b0, bus.mode_sel} < (MODE_W + 1)'(NUM_MODES));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        cur_d    = cur_q;
        inc_d    = inc_q;
        mod_d    = mod_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        acc_load = 1'b0;
        case (state_q)
            LOCKING: begin
                // Counts strobes since the (re)load; the LOCK_CYCLES-th one
                // moves us to RUN on the following edge.
                if (pix_ce) begin
                    if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RUN: begin
                if (bus.mode_req) begin
                    if (mode_ok) begin
                        pend_d  = bus.mode_sel;
                        state_d = DRAIN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Switch only right after a strobe has been delivered, so the
                // old-rate strobe is never cut short.
                if (pix_ce) begin
                    acc_load = 1'b1;
                    inc_d    = ACC_W'(mode_inc(pend_q));
                    mod_d    = ACC_W'(mode_mod(pend_q));
                    cur_d    = pend_q;
                    ack_d    = 1'b1;
                    cnt_d    = '0;
                    state_d  = LOCKING;
                end
            end
            default: begin
                state_d = LOCKING;
            end
        endcase
        locked_d = (state_d == RUN);
    end

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state_q  <= LOCKING;
            cnt_q    <= '0;
            pend_q   <= RST_MODE;
            cur_q    <= RST_MODE;
            inc_q    <= RST_INC;
            mod_q    <= RST_MOD;
            locked_q <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            cur_q    <= cur_d;
            inc_q    <= inc_d;
            mod_q    <= mod_d;
            locked_q <= locked_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy     = (state_q != RUN);
    assign bus.mode_ack = ack_q;
    assign bus.mode_err = err_q;
    assign bus.cur_mode = cur_q;
    assign bus.pix_ce   = pix_ce;
    assign bus.locked   = locked_q;

`ifdef PIX_CLK_OUT_EN
    logic clk_pix_q;

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            clk_pix_q <= 1'b0;
        end else begin
            clk_pix_q <= clk_pix_q ^ pix_ce;
        end
    end

    assign bus.clk_pix = clk_pix_q;
`endif

endmodule

// File: tb/tb_pix_clk_en_gen.sv
module tb_pix_clk_en_gen;

    localparam int LOCK = 16;

    logic clk    = 1'b0;
    logic resetn = 1'b1;

    initial forever #5 clk = ~clk;

    pix_clk_en_gen_if bus();

    pix_clk_en_gen #(
        .ACC_W        (16),
        .NUM_MODES    (4),
        .DEFAULT_MODE (0),
        .LOCK_CYCLES  (LOCK)
    ) dut (
        .clk_in (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Strobe k edges after a (re)load occurs when floor(k*INC/MOD) steps up.
    int T_INC [4] = '{1, 1007, 2, 13};
    int T_MOD [4] = '{4, 4000, 5, 20};

    int     m_mode = 0;
    int     m_pend = 0;
    int     m_ph   = 0;   // 0 locking, 1 run, 2 drain
    int     m_ns   = 0;   // strobes seen while locking
    longint m_k    = 0;   // edges since load
    bit     m_ce   = 0;
    bit     m_ack  = 0;
    bit     m_err  = 0;
    bit     mp_ce  = 0;

    function automatic bit strobe_at(input int m, input longint k);
        longint a, b;
        a = (k * T_INC[m]) / T_MOD[m];
        b = ((k - 1) * T_INC[m]) / T_MOD[m];
        return a != b;
    endfunction

    initial forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            m_mode = 0; m_pend = 0; m_ph = 0; m_ns = 0; m_k = 0;
            m_ce = 0; m_ack = 0; m_err = 0;
        end else begin
            mp_ce = m_ce;
            m_ack = 0;
            m_err = 0;
            if (m_ph == 2 && mp_ce) begin
                m_mode = m_pend;
                m_k    = 0;
                m_ce   = 0;
                m_ns   = 0;
                m_ack  = 1;
                m_ph   = 0;
            end else begin
                m_k++;
                m_ce = strobe_at(m_mode, m_k);
                if (m_ph == 0) begin
                    if (mp_ce) begin
                        m_ns++;
                        if (m_ns == LOCK) m_ph = 1;
                    end
                end else if (m_ph == 1 && bus.mode_req) begin
                    if (int'(bus.mode_sel) < 4) begin
                        m_pend = int'(bus.mode_sel);
                        m_ph   = 2;
                    end else begin
                        m_err = 1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (resetn) begin
            chk("pix_ce",   bus.pix_ce,   m_ce);
            chk("locked",   bus.locked,   m_ph == 1);
            chk("mode_ack", bus.mode_ack, m_ack);
            chk("mode_err", bus.mode_err, m_err);
            chk("busy",     bus.busy,     m_ph != 1);
            chk("cur_mode", bus.cur_mode, m_mode);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_req(input int sel);
        $display("req: sel=%0d busy=%0d cur_mode=%0d t=%0t", sel, bus.busy, bus.cur_mode, $time);
        bus.mode_sel = 4'(sel);
        bus.mode_req = 1'b1;
        step();
        bus.mode_req = 1'b0;
    endtask

    task automatic do_reset();
        $display("reset: t=%0t", $time);
        @(negedge clk);
        #2 resetn = 1'b0;
        repeat (3) @(negedge clk);
        #2 resetn = 1'b1;
    endtask

    task automatic wait_locked(input string nm);
        int n = 0;
        while (!bus.locked && n < 2000) begin
            step();
            n++;
        end
        chk({nm, "_lock_in_time"}, n < 2000, 1);
    endtask

    task automatic wait_ack(input string nm, output int n);
        n = 0;
        while (!bus.mode_ack && n < 200) begin
            step();
            n++;
        end
        chk({nm, "_ack_in_time"}, n < 200, 1);
    endtask

    task automatic wait_ce(input string nm);
        int n = 0;
        while (!bus.pix_ce && n < 50) begin
            step();
            n++;
        end
        chk({nm, "_ce_in_time"}, n < 50, 1);
    endtask

    // Called just after reset release: literal startup behaviour in mode 0.
    task automatic run_from_reset(input string nm);
        int first = 0, lk = 0, nce = 0, offp = 0, nack = 0;
        chk({nm, "_rst_pix_ce"}, bus.pix_ce, 0);
        chk({nm, "_rst_locked"}, bus.locked, 0);
        chk({nm, "_rst_busy"},   bus.busy, 1);
        chk({nm, "_rst_mode"},   bus.cur_mode, 0);
        chk({nm, "_rst_ack"},    bus.mode_ack, 0);
        chk({nm, "_rst_err"},    bus.mode_err, 0);
        for (int e = 1; e <= 70; e++) begin
            step();
            if (bus.pix_ce) begin
                if (first == 0) first = e;
                if (e <= 64) nce++;
                if (e % 4 != 0) offp++;
            end
            if (bus.locked && lk == 0) lk = e;
            if (bus.mode_ack) nack++;
        end
        chk({nm, "_first_ce_edge"}, first, 4);
        chk({nm, "_lock_edge"}, lk, 65);
        chk({nm, "_ce_count_64"}, nce, 16);
        chk({nm, "_off_period_ce"}, offp, 0);
        chk({nm, "_no_ack"}, nack, 0);
        chk({nm, "_mode0"}, bus.cur_mode, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n, d, cnt, last, mn, mx, s20, s, prev, nack, nerr;
        bus.mode_req = 1'b0;
        bus.mode_sel = 4'd0;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        #2 resetn = 1'b1;
        run_from_reset("start");

        // Mode 1: 1007 strobes in every 4000-cycle window, spacing 3 or 4.
        do_req(1);
        wait_locked("m1");
        chk("m1_cur_mode", bus.cur_mode, 1);
        cnt = 0; last = -1; mn = 99; mx = 0;
        for (int i = 0; i < 4000; i++) begin
            step();
            if (bus.pix_ce) begin
                if (last >= 0) begin
                    if (i - last < mn) mn = i - last;
                    if (i - last > mx) mx = i - last;
                end
                last = i;
                cnt++;
            end
        end
        chk("m1_strobes_4000", cnt, 1007);
        chk("m1_min_gap", mn, 3);
        chk("m1_max_gap", mx, 4);

        // 0 -> 3 while locked.
        do_req(0);
        wait_locked("m0");
        do_req(3);
        chk("sw3_locked_drop", bus.locked, 0);
        chk("sw3_busy", bus.busy, 1);
        prev = bus.pix_ce; n = 0;
        while (!bus.mode_ack && n < 50) begin
            prev = bus.pix_ce;
            step();
            n++;
        end
        chk("sw3_ack_in_time", n < 50, 1);
        chk("sw3_ack_after_strobe", prev, 1);
        chk("sw3_cur_mode", bus.cur_mode, 3);
        s20 = 0; s = 0; n = 0;
        while (!bus.locked && n < 300) begin
            step();
            n++;
            if (!bus.locked && bus.pix_ce) begin
                s++;
                if (n <= 20) s20++;
            end
        end
        chk("sw3_lock_in_time", n < 300, 1);
        chk("sw3_strobes_20", s20, 13);
        chk("sw3_strobes_to_lock", s, 16);

        // Out-of-range request.
        do_req(7);
        chk("err_pulse", bus.mode_err, 1);
        chk("err_locked", bus.locked, 1);
        chk("err_cur_mode", bus.cur_mode, 3);
        step();
        chk("err_single", bus.mode_err, 0);
        chk("err_locked2", bus.locked, 1);

        // Request during LOCKING is ignored.
        do_req(2);
        wait_ack("m2", d);
        step();
        chk("lk_busy", bus.busy, 1);
        do_req(1);
        nack = 0; nerr = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (bus.mode_ack) nack++;
            if (bus.mode_err) nerr++;
        end
        chk("lk_ignored_ack", nack, 0);
        chk("lk_ignored_err", nerr, 0);
        wait_locked("m2");
        chk("m2_cur_mode", bus.cur_mode, 2);

        // Request coinciding with a strobe waits for the following strobe.
        wait_ce("coin");
        chk("coin_locked", bus.locked, 1);
        do_req(0);
        wait_ack("coin", d);
        chk("coin_ack_delay_2or3", (d >= 2 && d <= 3), 1);
        chk("coin_cur_mode", bus.cur_mode, 0);
        wait_locked("coin");

        // Reset in the middle of DRAIN toward mode 2.
        wait_ce("rdr");
        step();
        do_req(2);
        chk("rdr_busy", bus.busy, 1);
        step();
        do_reset();
        run_from_reset("mid_drain");

        // Randomised requests and occasional resets, checked by the model.
        for (int it = 0; it < 80; it++) begin
            repeat ($urandom_range(0, 25)) step();
            if ($urandom_range(0, 19) == 0) do_reset();
            else do_req(int'($urandom_range(0, 7)));
        end
        repeat (100) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
